// File: rtl/seq_restoring_divider_16.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider_16
// Description : Multi-cycle restoring integer divider. One trial subtraction
//               (a + ~b + 1) per cycle produces one quotient bit. Operands
//               are captured on an accepted start, and a one-cycle done pulse
//               marks valid results.
// Build option: DIV_SIGNED_EN - two's-complement operands. Magnitudes are
//               divided unsigned, then a FIX cycle applies the signs
//               (quotient truncates toward zero, remainder follows the
//               dividend).
// Ports       :
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   start        in   1      request, sampled only while not busy
//   dividend     in   WIDTH  numerator, captured on accepted start
//   divisor      in   WIDTH  denominator, captured on accepted start
//   busy         out  1      operation in progress
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  result, held until next accepted start
//   remainder    out  WIDTH  result, held until next accepted start
//   div_by_zero  out  1      status of the last operation
// Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                c_CW       = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [c_CW-1:0]   c_CNT_INIT = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
    localparam logic [1:0] c_ST_FIX  = 2'd3;

    logic [1:0]       r_state;
    logic [WIDTH:0]   r_rem;        // partial remainder, one guard bit wide
    logic [WIDTH-1:0] r_q;          // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] r_d;
    logic [c_CW-1:0]  r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_carry;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_unused;

    // Shift {R,Q} left by one; R stays below D, so WIDTH+1 bits always hold it.
    assign w_shift = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};

    // Trial subtraction shift - D as shift + ~D + 1. Carry out set means the
    // difference is non-negative and the quotient bit is 1.
    assign w_trial    = {1'b0, w_shift} + {1'b0, ~{1'b0, r_d}}
                      + {{(WIDTH+1){1'b0}}, 1'b1};
    assign w_carry    = w_trial[WIDTH+1];
    assign w_diff     = w_trial[WIDTH:0];
    assign w_rem_next = w_carry ? w_diff : w_shift;
    assign w_q_next   = {r_q[WIDTH-2:0], w_carry};

    // The guard bit of the stored remainder is always zero between steps.
    assign w_unused = r_rem[WIDTH];

`ifdef DIV_SIGNED_EN
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // MIN_INT keeps its own bit pattern under negation, which is also the
    // correct unsigned magnitude, so MIN_INT/-1 falls out as MIN_INT rem 0.
    assign w_mag_a = dividend[WIDTH-1] ? (~dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : dividend;
    assign w_mag_b = divisor[WIDTH-1]  ? (~divisor  + {{(WIDTH-1){1'b0}}, 1'b1}) : divisor;
    assign w_q_fix = r_neg_q ? (~r_q + {{(WIDTH-1){1'b0}}, 1'b1}) : r_q;
    assign w_r_fix = r_neg_r ? (~r_rem[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                             : r_rem[WIDTH-1:0];
`else
    assign w_mag_a = dividend;
    assign w_mag_b = divisor;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_rem       <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                    if (start) begin
                        if (divisor == '0) begin
                            // No iteration needed: report straight away.
                            r_state     <= c_ST_DONE;
                            r_done      <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state <= c_ST_RUN;
                            r_busy  <= 1'b1;
                            r_dbz   <= 1'b0;
                            r_rem   <= '0;
                            r_q     <= w_mag_a;
                            r_d     <= w_mag_b;
                            r_cnt   <= c_CNT_INIT;
`ifdef DIV_SIGNED_EN
                            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_neg_r <= dividend[WIDTH-1];
`endif
                        end
                    end
                end

                c_ST_RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == '0) begin
`ifdef DIV_SIGNED_EN
                        r_state <= c_ST_FIX;
`else
                        r_state     <= c_ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next[WIDTH-1:0];
`endif
                    end
                end

`ifdef DIV_SIGNED_EN
                c_ST_FIX: begin
                    r_state     <= c_ST_DONE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_quotient  <= w_q_fix;
                    r_remainder <= w_r_fix;
                end
`endif

                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_restoring_divider_16
// Description : Directed bench for seq_restoring_divider_16 with
//               hand-computed expected results, reset/abort behaviour,
//               start-while-busy and back-to-back start in the done cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider_16;

    localparam int W = 16;
`ifdef DIV_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_restoring_divider_16 #(.WIDTH(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advances until done; cyc is the index of the current cycle after the
    // accepting edge (cycle 1 is the one right after it).
    task automatic wait_done(input int cyc0, output int cyc, output bit overlap);
        cyc     = cyc0;
        overlap = 1'b0;
        while (!done && cyc < 200) begin
            if (busy && done) overlap = 1'b1;
            tick;
            cyc++;
        end
        if (busy && done) overlap = 1'b1;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick;
        start    = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input int elat);
        int cyc;
        bit ov;
        launch(a, b);
        // Scramble operands: the captured copies must be used.
        dividend = ~a;
        divisor  = b ^ 16'h5A5A;
        chk({tag, "/busy_c1"}, 32'(busy), 32'(b != '0));
        wait_done(1, cyc, ov);
        chk({tag, "/latency"}, 32'(cyc), 32'(elat));
        chk({tag, "/quotient"}, 32'(quotient), 32'(eq));
        chk({tag, "/remainder"}, 32'(remainder), 32'(er));
        chk({tag, "/dbz"}, 32'(div_by_zero), 32'(edbz));
        chk({tag, "/busy_done_overlap"}, 32'(ov), 32'(0));
        tick;
        chk({tag, "/done_pulse_end"}, 32'(done), 32'(0));
        chk({tag, "/quotient_hold"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        int  cyc;
        bit  ov;
        bit  seen;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick;
        tick;
        chk("reset/busy", 32'(busy), 32'(0));
        chk("reset/done", 32'(done), 32'(0));
        chk("reset/quotient", 32'(quotient), 32'(0));
        chk("reset/remainder", 32'(remainder), 32'(0));
        chk("reset/dbz", 32'(div_by_zero), 32'(0));
        rst = 1'b0;
        tick;

        // Basic division.
        run_op("t1_100div7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, LAT);

        // Divide by zero: immediate done, busy never asserted.
        run_op("t2_dbz", 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1);

`ifdef DIV_SIGNED_EN
        run_op("t6_m7div2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, LAT);
        run_op("t6_minint", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, LAT);
        run_op("t6_7divm2", 16'd7, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, LAT);
        run_op("t6_dbz", 16'hFFF0, 16'h0000, 16'hFFFF, 16'hFFF0, 1'b1, 1);
`else
        run_op("t3_msb_divisor", 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, LAT);
        run_op("t3_div1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, LAT);
`endif

        // Dividend smaller than divisor.
        run_op("small_3div7", 16'd3, 16'd7, 16'd0, 16'd3, 1'b0, LAT);

        // Start while busy is ignored; results from 3/7 stay visible in RUN.
        launch(16'd50, 16'd5);
        tick;
        tick;
        tick;
        dividend = 16'd9;
        divisor  = 16'd3;
        start    = 1'b1;
        tick;
        start    = 1'b0;
        chk("t4/busy_during_ignored", 32'(busy), 32'(1));
        chk("t4/quotient_stable_run", 32'(quotient), 32'(0));
        chk("t4/remainder_stable_run", 32'(remainder), 32'(3));
        wait_done(5, cyc, ov);
        chk("t4/latency", 32'(cyc), 32'(LAT));
        chk("t4/quotient", 32'(quotient), 32'(10));
        chk("t4/remainder", 32'(remainder), 32'(0));
        // Back-to-back start in the done cycle.
        launch(16'd9, 16'd3);
        chk("t4b/busy_c1", 32'(busy), 32'(1));
        chk("t4b/done_c1", 32'(done), 32'(0));
        wait_done(1, cyc, ov);
        chk("t4b/latency", 32'(cyc), 32'(LAT));
        chk("t4b/quotient", 32'(quotient), 32'(3));
        chk("t4b/remainder", 32'(remainder), 32'(0));
        chk("t4b/overlap", 32'(ov), 32'(0));
        tick;

        // Reset aborts RUN without a done pulse.
        launch(16'd1000, 16'd3);
        repeat (7) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t5/busy", 32'(busy), 32'(0));
        chk("t5/done", 32'(done), 32'(0));
        chk("t5/quotient", 32'(quotient), 32'(0));
        chk("t5/remainder", 32'(remainder), 32'(0));
        chk("t5/dbz", 32'(div_by_zero), 32'(0));
        seen = 1'b0;
        repeat (LAT + 3) begin
            tick;
            if (done || busy) seen = 1'b1;
        end
        chk("t5/no_activity_after_abort", 32'(seen), 32'(0));
        run_op("t5_1000div3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
